// File: rtl/ram_burst_reader.sv
// ram_burst_reader: walks a wrapping address range of an async-read RAM,
// streams each byte on a valid/ready port and keeps a running checksum.
module ram_burst_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] burst_len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    // Remaining count is one bit wider so a full-memory burst (len 0) fits.
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              xfer, can_cap;

    assign xfer    = out_valid_q && out_ready;
    assign can_cap = !out_valid_q || out_ready;

    // Next-state and registered-output computation for the burst FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;

        // A handshake accumulates the word and empties the output slot,
        // unless READ refills it on the same edge below.
        if (xfer) begin
            checksum_d  = checksum_q + out_data_q;
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    rem_d      = (burst_len == '0) ? FULL_LEN : {1'b0, burst_len};
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (can_cap) begin
                    out_data_d  = ram_q;
                    out_valid_d = 1'b1;
                    ptr_d       = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rem_d       = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer) state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle raises done/drops busy; second returns to IDLE.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign ram_addr  = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, directed and random bursts checked
// against an address-list / running-sum reference.
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [6:0] base_addr, burst_len, ram_addr;
    logic [7:0] ram_q, out_data, checksum;
    logic       out_valid, busy, done;
    logic [7:0] mem [128];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign ram_q = mem[ram_addr];

    ram_burst_reader #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .ram_addr(ram_addr), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_csum"}, checksum, 0);
    endtask

    // mode: 0 ready=1, 1 random ready, 2 fixed toggle pattern, 3 stall+rewrite mem[20]
    // inj: pulse a foreign start mid-burst; abort_after>0: reset after that many handshakes
    task automatic run_burst(input int base, input int len, input int mode,
                             input bit inj, input int abort_after);
        int         L, k, sum, done_k;
        logic [7:0] exp[$];
        logic [7:0] got[$];
        logic [7:0] prev_data;
        bit         prev_stall, saw_done;
        int         pat[6] = '{1, 0, 0, 1, 0, 1};

        L = (len == 0) ? 128 : len;
        sum = 0;
        for (int i = 0; i < L; i++) begin
            exp.push_back(mem[(base + i) % 128]);
            sum = (sum + mem[(base + i) % 128]) % 256;
        end

        @(negedge clk);
        base_addr = 7'(base);
        burst_len = 7'(len);
        start = 1'b1;
        out_ready = 1'b1;
        k = -1;
        done_k = -1;
        prev_stall = 1'b0;
        prev_data = '0;
        while (1) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
            if (k > 3000) begin
                chk("timeout", 0, 1);
                return;
            end
            if (mode == 0 && k < L)
                chk("ram_addr", ram_addr, (base + k) % 128);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (inj && k == 2) begin
                start = 1'b1;
                base_addr = 7'd99;
                burst_len = 7'd1;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = (k >= 1 && k <= 6) ? pat[k-1][0] : 1'b1;
                default: begin
                    out_ready = (k >= 4);
                    if (k == 2) mem[20] = 8'h22;
                end
            endcase
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (abort_after > 0 && got.size() == abort_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset_vals("abort");
                saw_done = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (done) saw_done = 1'b1;
                end
                chk("abort_no_done", saw_done, 0);
                return;
            end
        end

        chk("count", got.size(), L);
        for (int i = 0; i < L && i < got.size(); i++)
            chk($sformatf("word%0d", i), got[i], exp[i]);
        if (mode == 3) chk("capture", got[0], 8'h11);
        chk("checksum", checksum, sum);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", out_valid, 0);
        if (mode == 0) chk("done_latency", done_k, L + 2);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("csum_hold", checksum, sum);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        burst_len = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        run_burst(5, 4, 0, 1'b0, 0);
        chk("csum_26", checksum, 8'h1A);
        run_burst(10, 3, 2, 1'b0, 0);
        chk("csum_33", checksum, 8'd33);
        run_burst(126, 4, 0, 1'b0, 0);
        chk("csum_fe", checksum, 8'hFE);

        for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
        run_burst(0, 0, 0, 1'b0, 0);
        chk("csum_80", checksum, 8'h80);

        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        run_burst(30, 6, 0, 1'b1, 0);
        run_burst(40, 6, 0, 1'b0, 2);
        run_burst(50, 3, 0, 1'b0, 0);

        mem[20] = 8'h11;
        run_burst(20, 2, 3, 1'b0, 0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            run_burst($urandom_range(0, 127), $urandom_range(0, 20), 1, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
